vga_fb_filler: RTL and testbench
================================

# vga_fb_filler

Hardware rectangle-fill engine that acts as the writer on the `vga_controller` framebuffer write port. It accepts one fill command (origin, size, RGB332 colour) and emits one pixel write per cycle on `waddr`/`wdata`/`sel_rw` until the rectangle is covered. It sits between the CPU command registers and `vga_controller`, replacing hard-wired write values with a programmable fill.

## Interface
Parameters:
- `H_RES`, 640, visible pixels per line; row stride in bytes
- `V_RES`, 480, visible lines
- `FB_BASE`, 32'h0000_0000, byte address of pixel (0,0)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  command strobe, sampled only when `busy`=0
- `x0`, `y0`  in  10 each  rectangle origin
- `w`, `h`  in  10 each  rectangle width/height in pixels
- `color`  in  8  RGB332 fill value {r[2:0],g[2:0],b[1:0]}
- `wr_hold`  in  1  sink stall; no write issued while high
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse at command completion
- `waddr`  out  32  framebuffer byte address
- `wdata`  out  8  pixel data
- `sel_rw`  out  1  0 = write this cycle, 1 = idle/no write

## Operation
- States: IDLE, FILL, DONE.
- IDLE: `sel_rw`=1. On `start`=1: latch `x0,y0,w,h,color`, compute `row_base = FB_BASE + y0*H_RES + x0` (one multiply at load), x-count=0, y-count=0. If effective `w`=0 or `h`=0 -> DONE, no writes; else -> FILL.
- FILL: per cycle with `wr_hold`=0: `sel_rw`=0, `waddr = row_base + xcnt`, `wdata` = latched colour; xcnt++. At xcnt=w-1: xcnt=0, `row_base += H_RES`, ycnt++. Write of (w-1,h-1) -> DONE.
- FILL with `wr_hold`=1: `sel_rw`=1, all counters, `waddr`, `wdata` held.
- DONE: `done`=1 for one cycle, `busy`=0, `sel_rw`=1 -> IDLE.
- `start` while `busy`=1 ignored; inputs other than `start` are don't-care outside the load cycle.
- Order: raster, x-major, top-left first. Address arithmetic 32-bit unsigned, wraps modulo 2^32.
- Reset (any time, including mid-FILL): IDLE; `busy`=0, `done`=0, `sel_rw`=1, `waddr`=0, `wdata`=0; command abandoned, no further writes.

## Timing
- Start sampled at edge N -> first write (`sel_rw`=0) presented cycles N+1; `busy`=1 from N+1.
- Unstalled fill: exactly w*h consecutive write cycles; `done` pulses the cycle after the last write; `busy` drops in that same cycle.
- Each stalled cycle extends the command by one; written sequence is unchanged.
- Zero-size command: `busy`=0, `done` pulses at N+1, no writes.
- `start` may be asserted in the `done` cycle and is accepted (back-to-back commands, one idle cycle between write bursts).
- All outputs registered.

## Configuration
- `VGA_FB_FILL_CLIP_EN` defined: at load, `x0>=H_RES` or `y0>=V_RES` -> zero-size; else w_eff=min(w,H_RES-x0), h_eff=min(h,V_RES-y0). No write ever lands outside the visible frame.
- Undefined: w,h used as given; writes past line end spill into next row, past frame end into memory beyond the framebuffer.

## Structure
- Shared package: state encoding (IDLE/FILL/DONE), `SEL_WRITE`=0/`SEL_IDLE`=1, RGB332 field widths, default H_RES/V_RES.
- One sub-module natural: `fb_clip` (combinational effective-size computation, instantiated only under `VGA_FB_FILL_CLIP_EN`).

## Test plan
- x0=0,y0=0,w=4,h=2,color=8'h1F -> 8 writes, addrs 0,1,2,3,640,641,642,643, wdata=8'h1F, `done` one cycle after the 8th.
- w=0,h=5 -> no `sel_rw`=0 cycle, `done` at N+1.
- w=3,h=1 with `wr_hold` high on 2nd write cycle for 2 cycles -> same 3 addresses, 5-cycle burst, outputs frozen while held.
- Clip enabled, x0=638,y0=479,w=10,h=10 -> 2 writes (addr 479*640+638, +639); disabled -> 100 writes.
- `rst` low mid-fill of 4x4 -> outputs go to reset values asynchronously; after release, no writes until new `start`.
- `start` during `busy` with different colour -> ignored; `start` in `done` cycle -> second fill begins next cycle.

Source files
------------

// File: rtl/vga_fb_filler_pkg.sv
// Shared definitions for the vga_fb_filler rectangle-fill engine:
// FSM state encoding, sel_rw levels, RGB332 field widths, default geometry.
package vga_fb_filler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // sel_rw levels on the framebuffer write port
    localparam logic SEL_WRITE = 1'b0;
    localparam logic SEL_IDLE  = 1'b1;

    // RGB332 pixel layout {r[2:0], g[2:0], b[1:0]}
    localparam int unsigned R_W   = 3;
    localparam int unsigned G_W   = 3;
    localparam int unsigned B_W   = 2;
    localparam int unsigned PIX_W = R_W + G_W + B_W;

    localparam int unsigned DEF_H_RES = 640;
    localparam int unsigned DEF_V_RES = 480;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned ADDR_W    = 32;

endpackage

// File: rtl/vga_fb_filler_fb_clip.sv
// fb_clip: combinational effective-size computation for a fill command.
// Used by vga_fb_filler only when VGA_FB_FILL_CLIP_EN is defined.
// Origin outside the visible frame yields a zero-size rectangle; otherwise
// width/height are trimmed so no pixel lands past the right or bottom edge.
module fb_clip
    import vga_fb_filler_pkg::*;
#(
    parameter int unsigned H_RES = DEF_H_RES,
    parameter int unsigned V_RES = DEF_V_RES
) (
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_w,
    input  logic [COORD_W-1:0] i_h,
    output logic [COORD_W-1:0] o_w_eff,
    output logic [COORD_W-1:0] o_h_eff
);

    logic [31:0] w_x_room;
    logic [31:0] w_y_room;

    // Room left to the right of / below the origin, then min() against the request
    always_comb begin
        w_x_room = '0;
        w_y_room = '0;
        o_w_eff  = '0;
        o_h_eff  = '0;
        if ((32'(i_x0) < H_RES) && (32'(i_y0) < V_RES)) begin
            w_x_room = H_RES - 32'(i_x0);
            w_y_room = V_RES - 32'(i_y0);
            o_w_eff  = (32'(i_w) < w_x_room) ? i_w : COORD_W'(w_x_room);
            o_h_eff  = (32'(i_h) < w_y_room) ? i_h : COORD_W'(w_y_room);
        end
    end

endmodule

// File: rtl/vga_fb_filler.sv
// vga_fb_filler: rectangle-fill engine driving the vga_controller
// framebuffer write port, one pixel per unstalled cycle in raster order.
// Optional clipping to the visible frame: define VGA_FB_FILL_CLIP_EN.
module vga_fb_filler
    import vga_fb_filler_pkg::*;
#(
    parameter int unsigned H_RES   = DEF_H_RES,
    parameter int unsigned V_RES   = DEF_V_RES,
    parameter logic [31:0] FB_BASE = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic [PIX_W-1:0]   color,
    input  logic               wr_hold,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  waddr,
    output logic [PIX_W-1:0]   wdata,
    output logic               sel_rw
);

    if (H_RES == 0 || V_RES == 0) begin : g_res_check
        $error("vga_fb_filler: H_RES and V_RES must be non-zero");
    end

    fill_state_t        r_state;
    logic [COORD_W-1:0] r_w;
    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_xcnt;
    logic [COORD_W-1:0] r_ycnt;
    logic [ADDR_W-1:0]  r_row_base;
    logic [PIX_W-1:0]   r_color;
    logic               r_last;

    logic [COORD_W-1:0] w_w_eff;
    logic [COORD_W-1:0] w_h_eff;

`ifdef VGA_FB_FILL_CLIP_EN
    fb_clip #(
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_clip (
        .i_x0    (x0),
        .i_y0    (y0),
        .i_w     (w),
        .i_h     (h),
        .o_w_eff (w_w_eff),
        .o_h_eff (w_h_eff)
    );
`else
    assign w_w_eff = w;
    assign w_h_eff = h;
`endif

    logic               w_load;
    logic               w_zero;
    logic [ADDR_W-1:0]  w_load_base;
    logic [COORD_W-1:0] w_cur_x;
    logic [COORD_W-1:0] w_cur_y;
    logic [COORD_W-1:0] w_cur_w;
    logic [COORD_W-1:0] w_cur_h;
    logic [ADDR_W-1:0]  w_cur_base;
    logic [PIX_W-1:0]   w_cur_color;
    logic               w_row_end;
    logic               w_is_last;
    logic               w_present;

    // Raster cursor: on a load cycle the cursor is the freshly computed origin
    // so the first pixel is presented the cycle right after start is sampled.
    always_comb begin
        w_load      = start && (r_state != ST_FILL);
        w_zero      = (w_w_eff == '0) || (w_h_eff == '0);
        w_load_base = FB_BASE + (32'(y0) * H_RES) + 32'(x0);
        w_cur_x     = w_load ? '0          : r_xcnt;
        w_cur_y     = w_load ? '0          : r_ycnt;
        w_cur_w     = w_load ? w_w_eff     : r_w;
        w_cur_h     = w_load ? w_h_eff     : r_h;
        w_cur_base  = w_load ? w_load_base : r_row_base;
        w_cur_color = w_load ? color       : r_color;
        w_row_end   = (w_cur_x == w_cur_w - 1'b1);
        w_is_last   = w_row_end && (w_cur_y == w_cur_h - 1'b1);
        w_present   = !wr_hold &&
                      ((w_load && !w_zero) || ((r_state == ST_FILL) && !r_last));
    end

    // Command FSM with registered write-port outputs; a presented pixel
    // overrides the cursor values latched at load (later assignment wins).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_w        <= '0;
            r_h        <= '0;
            r_xcnt     <= '0;
            r_ycnt     <= '0;
            r_row_base <= '0;
            r_color    <= '0;
            r_last     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            sel_rw     <= SEL_IDLE;
        end else begin
            done   <= 1'b0;
            sel_rw <= SEL_IDLE;
            if (w_load) begin
                r_w        <= w_w_eff;
                r_h        <= w_h_eff;
                r_color    <= color;
                r_xcnt     <= '0;
                r_ycnt     <= '0;
                r_row_base <= w_load_base;
                r_last     <= 1'b0;
                if (w_zero) begin
                    r_state <= ST_DONE;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    r_state <= ST_FILL;
                    busy    <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_FILL: begin
                        if (r_last) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                    ST_DONE: r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
            if (w_present) begin
                sel_rw     <= SEL_WRITE;
                waddr      <= w_cur_base + 32'(w_cur_x);
                wdata      <= w_cur_color;
                r_xcnt     <= w_row_end ? '0 : w_cur_x + 1'b1;
                r_ycnt     <= w_row_end ? w_cur_y + 1'b1 : w_cur_y;
                r_row_base <= w_row_end ? w_cur_base + H_RES : w_cur_base;
                r_last     <= w_is_last;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_filler.sv
// Self-checking bench for vga_fb_filler: directed and random fill commands
// compared against a raster-order address list built from plain arithmetic.
module tb_vga_fb_filler;

    localparam int          H    = 640;
    localparam int          V    = 480;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  x0 = '0, y0 = '0, w = '0, h = '0;
    logic [7:0]  color = '0;
    logic        wr_hold = 1'b0;
    logic        busy, done, sel_rw;
    logic [31:0] waddr;
    logic [7:0]  wdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q[$];

    vga_fb_filler #(
        .H_RES   (H),
        .V_RES   (V),
        .FB_BASE (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .x0      (x0),
        .y0      (y0),
        .w       (w),
        .h       (h),
        .color   (color),
        .wr_hold (wr_hold),
        .busy    (busy),
        .done    (done),
        .waddr   (waddr),
        .wdata   (wdata),
        .sel_rw  (sel_rw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected write addresses for one command, in raster order
    task automatic build(input int cx, input int cy, input int cw, input int ch);
        int we, he;
        we = cw;
        he = ch;
`ifdef VGA_FB_FILL_CLIP_EN
        if (cx >= H || cy >= V) begin
            we = 0;
            he = 0;
        end else begin
            if (we > H - cx) we = H - cx;
            if (he > V - cy) he = V - cy;
        end
`endif
        exp_q.delete();
        for (int yy = 0; yy < he; yy++)
            for (int xx = 0; xx < we; xx++)
                exp_q.push_back(BASE + 32'((cy + yy) * H + cx + xx));
    endtask

    function automatic logic pick_hold(input int mode, input logic [63:0] mask, input int cyc);
        if (mode == 1) return (cyc < 64) ? mask[cyc] : 1'b0;
        if (mode == 2) return ($urandom_range(0, 3) == 0);
        return 1'b0;
    endfunction

    // Issue one command at the current negedge and follow it to its done cycle.
    // Returns at the negedge inside the done cycle, so a following call asserts
    // start during that done cycle.
    task automatic run_cmd(input int cx, input int cy, input int cw, input int ch,
                           input logic [7:0] ccol, input int hold_mode,
                           input logic [63:0] hold_mask, input bit noise, input string tag);
        int          cyc, limit;
        logic        prev_hold, done_seen, have_wr;
        logic [31:0] last_addr;
        build(cx, cy, cw, ch);
        limit     = 4 * cw * ch + 40;
        x0        = 10'(cx);
        y0        = 10'(cy);
        w         = 10'(cw);
        h         = 10'(ch);
        color     = ccol;
        start     = 1'b1;
        cyc       = 0;
        prev_hold = pick_hold(hold_mode, hold_mask, 0);
        wr_hold   = prev_hold;
        done_seen = 1'b0;
        have_wr   = 1'b0;
        last_addr = '0;
        @(negedge clk);
        start = 1'b0;
        while (!done_seen && cyc < limit) begin
            if (exp_q.size() == 0) begin
                chk({tag, " done"},   32'(done),   32'd1);
                chk({tag, " busy@d"}, 32'(busy),   32'd0);
                chk({tag, " sel@d"},  32'(sel_rw), 32'd1);
                done_seen = 1'b1;
            end else begin
                chk({tag, " sel"},  32'(sel_rw), prev_hold ? 32'd1 : 32'd0);
                chk({tag, " done0"}, 32'(done),  32'd0);
                chk({tag, " busy"}, 32'(busy),   32'd1);
                if (!prev_hold) begin
                    chk({tag, " waddr"}, waddr, exp_q[0]);
                    chk({tag, " wdata"}, 32'(wdata), 32'(ccol));
                    last_addr = exp_q[0];
                    have_wr   = 1'b1;
                    void'(exp_q.pop_front());
                end else if (have_wr) begin
                    chk({tag, " hold addr"}, waddr, last_addr);
                    chk({tag, " hold data"}, 32'(wdata), 32'(ccol));
                end
                cyc++;
                prev_hold = pick_hold(hold_mode, hold_mask, cyc);
                wr_hold   = prev_hold;
                if (noise) begin
                    start = 1'($urandom_range(0, 1));
                    x0    = 10'($urandom);
                    y0    = 10'($urandom);
                    w     = 10'($urandom);
                    h     = 10'($urandom);
                    color = ~ccol;
                end
                @(negedge clk);
            end
        end
        if (!done_seen) chk({tag, " timeout"}, 32'd0, 32'd1);
        start   = 1'b0;
        wr_hold = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk({tag, " idle sel"},  32'(sel_rw), 32'd1);
            chk({tag, " idle busy"}, 32'(busy),   32'd0);
            chk({tag, " idle done"}, 32'(done),   32'd0);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst sel",   32'(sel_rw), 32'd1);
        chk("rst busy",  32'(busy),   32'd0);
        chk("rst done",  32'(done),   32'd0);
        chk("rst waddr", waddr,       32'd0);
        chk("rst wdata", 32'(wdata),  32'd0);
        rst = 1'b1;
        idle(2, "post-rst");

        // Directed cases
        run_cmd(0, 0, 4, 2, 8'h1F, 0, '0, 1'b0, "r4x2");
        idle(1, "r4x2");
        run_cmd(5, 5, 0, 5, 8'h44, 0, '0, 1'b0, "w0");
        idle(1, "w0");
        run_cmd(7, 9, 6, 0, 8'h45, 0, '0, 1'b0, "h0");
        idle(1, "h0");
        run_cmd(10, 3, 3, 1, 8'hA5, 1, 64'h6, 1'b0, "hold");
        idle(1, "hold");
        run_cmd(638, 479, 10, 10, 8'h3C, 0, '0, 1'b0, "corner");
        idle(2, "corner");
        run_cmd(20, 20, 5, 3, 8'h77, 0, '0, 1'b1, "noise");
        run_cmd(100, 50, 2, 2, 8'hC3, 0, '0, 1'b0, "b2b");
        idle(1, "b2b");

        // Reset in the middle of a 4x4 fill
        x0 = 10'd30; y0 = 10'd40; w = 10'd4; h = 10'd4; color = 8'hE0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst sel",   32'(sel_rw), 32'd1);
        chk("arst busy",  32'(busy),   32'd0);
        chk("arst done",  32'(done),   32'd0);
        chk("arst waddr", waddr,       32'd0);
        chk("arst wdata", 32'(wdata),  32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(4, "after-arst");
        run_cmd(1, 2, 3, 2, 8'h5A, 0, '0, 1'b0, "post-arst");
        idle(1, "post-arst");

        // Randomised commands: random holds, noise, gaps of 0..2 idle cycles
        for (int i = 0; i < 25; i++) begin
            int rx, ry, rw, rh, gap;
            rx  = (i % 3 == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 1023);
            ry  = (i % 4 == 0) ? $urandom_range(460, 1023) : $urandom_range(0, 1023);
            rw  = $urandom_range(0, 12);
            rh  = $urandom_range(0, 6);
            gap = $urandom_range(0, 2);
            run_cmd(rx, ry, rw, rh, 8'($urandom), ($urandom_range(0, 1) == 1) ? 2 : 0,
                    '0, 1'($urandom_range(0, 1)), "rand");
            if (gap > 0) idle(gap, "rand");
        end
        idle(2, "end");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
